// File: rtl/wwd_display_if.sv
// wwd_display_if: WWD strobe/data bus from the CPU (master) to the display block (slave).
interface wwd_display_if;
  logic        wwd_valid;
  logic [15:0] wwd_data;

  modport master (output wwd_valid, output wwd_data);
  modport slave  (input  wwd_valid, input  wwd_data);
endinterface

// File: rtl/wwd_display.sv
// wwd_display: buffers CPU WWD words in a FIFO and scans the oldest word onto a 4-digit
// active-low 7-segment display; define WWD_DISPLAY_AUTO_EN for timed auto-advance.
module wwd_display #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned SCAN_DIV    = 16,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  wwd_display_if.slave             i_wwd,
  input  logic [7:0]               i_pc_low,
  input  logic                     i_advance,
  output logic [6:0]               o_seg_n,
  output logic [3:0]               o_an_n,
  output logic [7:0]               o_led,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SCAN_DIV < 2 || HOLD_CYCLES < 1) begin : g_bad_param
      $error("wwd_display: illegal parameter combination");
    end
  endgenerate

  logic [15:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_empty;
  logic          r_full;
  logic          r_overflow;
  logic          r_adv_s1;
  logic          r_adv_s2;
  logic          r_adv_s3;
  logic [DW-1:0] r_div;
  logic [1:0]    r_digit;
  logic [6:0]    r_seg_n;
  logic [3:0]    r_an_n;
  logic [7:0]    r_led;

  logic          w_pop_req;
  logic          w_auto_pop;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_count_nxt;
  logic [15:0]   w_head;
  logic [3:0]    w_nibble;

  function automatic logic [6:0] f_hex(input logic [3:0] i_nib);
    case (i_nib)
      4'h0:    f_hex = 7'h40;
      4'h1:    f_hex = 7'h79;
      4'h2:    f_hex = 7'h24;
      4'h3:    f_hex = 7'h30;
      4'h4:    f_hex = 7'h19;
      4'h5:    f_hex = 7'h12;
      4'h6:    f_hex = 7'h02;
      4'h7:    f_hex = 7'h78;
      4'h8:    f_hex = 7'h00;
      4'h9:    f_hex = 7'h10;
      4'hA:    f_hex = 7'h08;
      4'hB:    f_hex = 7'h03;
      4'hC:    f_hex = 7'h46;
      4'hD:    f_hex = 7'h21;
      4'hE:    f_hex = 7'h06;
      default: f_hex = 7'h0E;
    endcase
  endfunction

`ifdef WWD_DISPLAY_AUTO_EN
  logic [HW-1:0] r_dwell;

  // Dwell timer: runs only while a word is queued behind the displayed one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dwell <= '0;
    end else if (w_pop) begin
      r_dwell <= '0;
    end else if (r_count >= CW'(2)) begin
      r_dwell <= r_dwell + HW'(1);
    end
  end

  assign w_auto_pop = (r_dwell == HW'(HOLD_CYCLES - 1)) && (r_count >= CW'(2));
`else
  assign w_auto_pop = 1'b0;
`endif

  assign w_pop_req = r_adv_s2 & ~r_adv_s3;
  assign w_pop     = (w_pop_req | w_auto_pop) & ~r_empty;
  // A pop frees a slot, so a full FIFO still accepts the word arriving alongside it.
  assign w_push    = i_wwd.wwd_valid & (~r_full | w_pop);
  assign w_drop    = i_wwd.wwd_valid & r_full & ~w_pop;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_nibble  = w_head[{r_digit, 2'b00} +: 4];

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage is deliberately left uninitialised; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= i_wwd.wwd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_adv_s1   <= 1'b0;
      r_adv_s2   <= 1'b0;
      r_adv_s3   <= 1'b0;
      r_div      <= '0;
      r_digit    <= '0;
      r_seg_n    <= 7'h7F;
      r_an_n     <= 4'hF;
      r_led      <= '0;
    end else begin
      r_adv_s1 <= i_advance;
      r_adv_s2 <= r_adv_s1;
      r_adv_s3 <= r_adv_s2;

      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count    <= w_count_nxt;
      r_empty    <= (w_count_nxt == '0);
      r_full     <= (w_count_nxt == CW'(DEPTH));
      r_overflow <= r_overflow | w_drop;

      if (r_div == DW'(SCAN_DIV - 1)) begin
        r_div   <= '0;
        r_digit <= r_digit + 2'd1;
      end else begin
        r_div <= r_div + DW'(1);
      end

      r_an_n  <= ~(4'b0001 << r_digit);
      r_seg_n <= r_empty ? 7'h3F : f_hex(w_nibble);
      r_led   <= i_pc_low;
    end
  end

  assign o_seg_n    = r_seg_n;
  assign o_an_n     = r_an_n;
  assign o_led      = r_led;
  assign o_count    = r_count;
  assign o_empty    = r_empty;
  assign o_full     = r_full;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_wwd_display.sv
// tb_wwd_display: table-driven, directed and random checks of wwd_display against a queue model.
module tb_wwd_display;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned HOLD     = 1024;
  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    pc_low;
  logic          advance;
  logic [6:0]    seg_n;
  logic [3:0]    an_n;
  logic [7:0]    led;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;

  wwd_display_if bus ();

  wwd_display #(.DEPTH(DEPTH), .SCAN_DIV(SCAN_DIV), .HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_wwd      (bus),
    .i_pc_low   (pc_low),
    .i_advance  (advance),
    .o_seg_n    (seg_n),
    .o_an_n     (an_n),
    .o_led      (led),
    .o_count    (count),
    .o_empty    (empty),
    .o_full     (full),
    .o_overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [15:0] mq[$];
  bit          m_ovf;
  bit          h0, h1, h2;
  int          t_run;
  logic [6:0]  m_seg;
  logic [3:0]  m_an;
  logic [7:0]  m_led;
`ifdef WWD_DISPLAY_AUTO_EN
  int          m_dwell;
`endif

  typedef struct {
    bit          valid;
    logic [15:0] data;
    int          exp_count;
    bit          exp_full;
    bit          exp_ovf;
  } vec_t;

  vec_t fill_tbl [DEPTH+1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare all outputs.
  task automatic tick();
    bit          pre_empty;
    logic [15:0] pre_head;
    bit          pop_req;
    bit          auto_pop;
    bit          pop;
    int          dig;
    @(posedge clk);
    pre_empty = (mq.size() == 0);
    pre_head  = pre_empty ? 16'h0 : mq[0];
    if (reset) begin
      mq.delete();
      m_ovf = 0; h0 = 0; h1 = 0; h2 = 0; t_run = 0;
      m_seg = 7'h7F; m_an = 4'hF; m_led = 8'h00;
`ifdef WWD_DISPLAY_AUTO_EN
      m_dwell = 0;
`endif
    end else begin
      pop_req  = h1 && !h2;
      auto_pop = 1'b0;
`ifdef WWD_DISPLAY_AUTO_EN
      auto_pop = (m_dwell == int'(HOLD) - 1) && (mq.size() >= 2);
`endif
      pop = (pop_req || auto_pop) && (mq.size() > 0);
`ifdef WWD_DISPLAY_AUTO_EN
      if (pop) m_dwell = 0;
      else if (mq.size() >= 2) m_dwell++;
`endif
      if (pop) void'(mq.pop_front());
      if (bus.wwd_valid) begin
        if (mq.size() < DEPTH) mq.push_back(bus.wwd_data);
        else m_ovf = 1;
      end
      h2 = h1; h1 = h0; h0 = advance;
      t_run++;
      dig   = ((t_run - 1) / SCAN_DIV) % 4;
      m_an  = 4'(~(4'b0001 << dig));
      m_seg = pre_empty ? 7'h3F : DEC[pre_head[4*dig +: 4]];
      m_led = pc_low;
    end
    #1;
    chk("model_count", 32'(count), 32'(mq.size()));
    chk("model_empty", 32'(empty), 32'(mq.size() == 0));
    chk("model_full", 32'(full), 32'(mq.size() == DEPTH));
    chk("model_overflow", 32'(overflow), 32'(m_ovf));
    chk("model_led", 32'(led), 32'(m_led));
    chk("model_an_n", 32'(an_n), 32'(m_an));
    chk("model_seg_n", 32'(seg_n), 32'(m_seg));
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    bus.wwd_valid = 1'b0;
    advance = 1'b0;
    tick();
    chk("reset_seg_n", 32'(seg_n), 32'h7F);
    chk("reset_an_n", 32'(an_n), 32'hF);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    reset = 1'b0;
  endtask

  task automatic push(input logic [15:0] w);
    bus.wwd_valid = 1'b1;
    bus.wwd_data  = w;
    tick();
    bus.wwd_valid = 1'b0;
  endtask

  task automatic pulse_pop();
    advance = 1'b1;
    tick();
    advance = 1'b0;
    tick();
    tick();
  endtask

  // Walk one full scan and confirm each digit decodes the expected word.
  task automatic show_word(input logic [15:0] w);
    logic [15:0] wv;
    logic [3:0]  want_an;
    int          k;
    wv = w;
    tick();
    for (int i = 0; i < 4; i++) begin
      want_an = 4'(~(4'b0001 << i));
      k = 0;
      while (an_n !== want_an && k < int'(4*SCAN_DIV + 2)) begin
        tick();
        k++;
      end
      if (an_n !== want_an) chk("scan_timeout", 32'(an_n), 32'(want_an));
      else chk("digit_seg", 32'(seg_n), 32'(DEC[wv[4*i +: 4]]));
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pct;
    for (int i = 0; i <= int'(DEPTH); i++) begin
      fill_tbl[i].valid     = 1'b1;
      fill_tbl[i].data      = 16'(i);
      fill_tbl[i].exp_count = (i < int'(DEPTH)) ? i + 1 : int'(DEPTH);
      fill_tbl[i].exp_full  = (i >= int'(DEPTH) - 1);
      fill_tbl[i].exp_ovf   = (i == int'(DEPTH));
    end

    reset = 1'b1;
    pc_low = 8'h1B;
    bus.wwd_valid = 1'b0;
    bus.wwd_data  = 16'h0;
    advance = 1'b0;

    // Reset then idle: dashes, digit scan order and LED echo
    reset_dut();
    tick();
    chk("idle_an0", 32'(an_n), 32'hE);
    chk("idle_seg_dash", 32'(seg_n), 32'h3F);
    chk("idle_led", 32'(led), 32'h1B);
    repeat (SCAN_DIV) tick();
    chk("idle_an1", 32'(an_n), 32'hD);
    repeat (3*SCAN_DIV) tick();

    // Single push
    push(16'h1234);
    chk("single_count", 32'(count), 32'd1);
    show_word(16'h1234);

    // Fill past full from the table, then drain in order
    reset_dut();
    for (int i = 0; i <= int'(DEPTH); i++) begin
      bus.wwd_valid = fill_tbl[i].valid;
      bus.wwd_data  = fill_tbl[i].data;
      tick();
      chk("fill_count", 32'(count), 32'(fill_tbl[i].exp_count));
      chk("fill_full", 32'(full), 32'(fill_tbl[i].exp_full));
      chk("fill_ovf", 32'(overflow), 32'(fill_tbl[i].exp_ovf));
    end
    bus.wwd_valid = 1'b0;
    show_word(16'h0000);
    for (int k = 0; k < int'(DEPTH); k++) begin
      pulse_pop();
      chk("drain_count", 32'(count), 32'(int'(DEPTH) - 1 - k));
      if (k < int'(DEPTH) - 1) show_word(16'(k + 1));
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Simultaneous push and pop while full
    reset_dut();
    for (int i = 0; i < int'(DEPTH); i++) push(16'(16'hA000 + i));
    chk("sim_full_pre", 32'(full), 32'd1);
    advance = 1'b1;
    tick();
    tick();
    bus.wwd_valid = 1'b1;
    bus.wwd_data  = 16'hABCD;
    tick();
    bus.wwd_valid = 1'b0;
    advance = 1'b0;
    chk("sim_full_count", 32'(count), 32'(DEPTH));
    chk("sim_full_ovf", 32'(overflow), 32'd0);
    tick();

    // Simultaneous push and pop request while empty
    reset_dut();
    advance = 1'b1;
    tick();
    tick();
    bus.wwd_valid = 1'b1;
    bus.wwd_data  = 16'h5A5A;
    tick();
    bus.wwd_valid = 1'b0;
    advance = 1'b0;
    chk("sim_empty_count", 32'(count), 32'd1);
    show_word(16'h5A5A);

    // Held button pops exactly once, on the third edge
    reset_dut();
    push(16'hBEEF);
    push(16'hCAFE);
    advance = 1'b1;
    tick();
    chk("held_edge1", 32'(count), 32'd2);
    tick();
    chk("held_edge2", 32'(count), 32'd2);
    tick();
    chk("held_edge3", 32'(count), 32'd1);
    repeat (97) tick();
    chk("held_end", 32'(count), 32'd1);
    advance = 1'b0;
    tick();

    // Reset while a pop is in the synchronizer
    reset_dut();
    push(16'h1111);
    advance = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    chk("rst_pending_count", 32'(count), 32'd0);
    reset = 1'b0;
    advance = 1'b0;
    push(16'h2222);
    repeat (5) tick();
    chk("rst_pending_nopop", 32'(count), 32'd1);

    // Random traffic, heavy then light push rate
    for (int c = 0; c < 3000; c++) begin
      pct = (c < 1500) ? 45 : 6;
      bus.wwd_valid = ($urandom_range(0, 99) < pct);
      bus.wwd_data  = 16'($urandom);
      pc_low        = 8'($urandom);
      if ($urandom_range(0, 5) == 0) advance = ~advance;
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    advance = 1'b0;
    bus.wwd_valid = 1'b0;

`ifdef WWD_DISPLAY_AUTO_EN
    // Auto-advance drains down to the last word and leaves it displayed
    reset_dut();
    push(16'h11AA);
    push(16'h22BB);
    push(16'h33CC);
    repeat (3*HOLD + 20) tick();
    chk("auto_count", 32'(count), 32'd1);
    show_word(16'h33CC);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
